fixed_weight_tile_streamer: RTL
===============================

Name: fixed_weight_tile_streamer

Overview:
- Transmit side of the projection-weight valid/ready stream consumed by the attention and linear blocks (e.g. the q/k/v/o projection weight ports).
- Loads one weight matrix as parallel tiles into on-chip registers, then replays it tile-by-tile REPEAT times: one pass per input-row block the consumer processes.
- Sits between the weight loader or DMA and each projection weight port; one instance per projection.

Parameters:
- WEIGHT_PRECISION_0, 8: element bit width.
- WEIGHT_TENSOR_SIZE_DIM_0, 4: matrix columns.
- WEIGHT_TENSOR_SIZE_DIM_1, 4: matrix rows.
- WEIGHT_PARALLELISM_DIM_0, 2: tile columns.
- WEIGHT_PARALLELISM_DIM_1, 2: tile rows.
- REPEAT, 2: full-matrix passes per load; must be >= 1.
- Derived localparams:
  - P = PAR_DIM_0 * PAR_DIM_1
  - TILES_0 = SIZE_DIM_0 / PAR_DIM_0
  - TILES_1 = SIZE_DIM_1 / PAR_DIM_1
  - NUM_TILES = TILES_0 * TILES_1
  - Both sizes must divide exactly; elaboration fails otherwise.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-low reset.
- load_data, input, [WEIGHT_PRECISION_0-1:0] x [P-1:0]: one tile, supplied in row-major tile order.
- load_valid, input, 1: load tile valid.
- load_ready, output, 1: high only in LOAD state.
- flush, input, 1: synchronous abort; return to LOAD.
- weight, output, [WEIGHT_PRECISION_0-1:0] x [P-1:0]: output tile.
- weight_valid, output, 1: output tile valid.
- weight_ready, input, 1: consumer ready.
- pass_done, output, 1: one-cycle pulse on the handshake of the last tile of each pass.

Behaviour:
- States: LOAD, STREAM.
- Reset (rst low, asynchronous):
  - state = LOAD; tile and pass counters = 0.
  - load_ready = 1, weight_valid = 0, pass_done = 0, weight = 0.
  - Storage contents are don't-care.
- LOAD:
  - Each load handshake writes storage[tile_cnt] and increments tile_cnt.
  - On the handshake with tile_cnt == NUM_TILES-1: tile_cnt = 0, pass_cnt = 0, go to STREAM, load_ready drops next cycle.
- STREAM:
  - Output is registered. The first tile is presented with weight_valid = 1 on the cycle after the final load handshake.
  - Sustains one tile per cycle while weight_ready = 1.
  - weight and weight_valid stay stable while weight_valid && !weight_ready (AXI-stream rule). weight_valid never drops without a handshake, except on flush or reset.
- Tile order: row-major, tile column index fastest: index = r*TILES_0 + c.
- Counters:
  - tile_cnt wraps NUM_TILES-1 -> 0 on handshake.
  - At wrap, pass_done pulses and pass_cnt increments.
  - On the wrap with pass_cnt == REPEAT-1: weight_valid = 0 next cycle, go to LOAD, load_ready = 1 next cycle. No bubble beyond that single transition cycle.
- flush:
  - In any state: next cycle state = LOAD, counters = 0, weight_valid = 0, pass_done = 0.
  - Flush has priority over a simultaneous handshake; that handshake's tile counts as not transferred.
- NUM_TILES == 1 and REPEAT == 1 are legal. The same tile is repeated back-to-back.
- No arithmetic on data; counter widths are $clog2 of NUM_TILES and REPEAT, minimum 1 bit.

Optional Feature:
- Macro: FIXED_WEIGHT_STREAMER_TRANSPOSE_EN.
- Defined: replay order is column-major at tile level (index = c*TILES_1 + r, row index fastest). Each tile's elements are transposed on output: out[j*PAR_DIM_1+i] = stored[i*PAR_DIM_0+j]. This supplies weights to consumers instantiated with WEIGHTS_PRE_TRANSPOSED = 0.
- Undefined: row-major replay, elements unchanged.
- Load order is identical in both cases.

Decomposition:
- Shared package fixed_weight_streamer_pkg:
  - state enum type (LOAD, STREAM).
  - Function computing the tile index from (r, c, transpose flag).
- One natural sub-module, weight_tile_replay_counter: nested tile-row, tile-column and pass counters with wrap and last flags. The top holds storage, FSM and the output register.

Test Plan (default params: 4 tiles, REPEAT=2; tile k filled with elements 16k..16k+3):
- Basic replay: load tiles 0..3 back-to-back; hold weight_ready = 1.
  - weight_valid rises 1 cycle after the last load.
  - Output tile sequence 0,1,2,3,0,1,2,3 on 8 consecutive cycles.
  - pass_done high on cycles 4 and 8.
  - load_ready = 1 on cycle 9.
- Backpressure: toggle weight_ready 1,0,0,1 during STREAM.
  - weight holds tile 1 stable across the stalled cycles.
  - No tile is skipped or duplicated; 8 handshakes total.
- Load gating: assert load_valid with data 0xFF throughout STREAM.
  - load_ready = 0; storage is unchanged; the second pass still outputs tiles 0..3.
- Flush mid-stream: flush at the handshake of tile 2 in pass 0.
  - Next cycle: weight_valid = 0, load_ready = 1, pass_done never pulses.
  - A new load of 4 tiles then replays from tile 0.
- Reset mid-operation: drive rst low asynchronously, mid-cycle, during STREAM.
  - weight_valid = 0 and load_ready = 1 immediately.
  - After release, only a full reload produces output.
- Transpose build: define FIXED_WEIGHT_STREAMER_TRANSPOSE_EN.
  - Tile order 0,2,1,3.
  - Tile 0 elements appear as 0,2,1,3.

Source files
------------

// File: rtl/fixed_weight_tile_streamer_pkg.sv
// Shared types and helpers for the fixed-weight tile streamer.
// Optional macro FIXED_WEIGHT_STREAMER_TRANSPOSE_EN selects column-major, element-transposed replay.
package fixed_weight_streamer_pkg;

   typedef enum logic [0:0] {
      ST_LOAD   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   // Sequence position of tile (r, c): row-major when transpose is 0, column-major otherwise.
   function automatic int tile_index(input int r, input int c, input int tiles_0,
                                     input int tiles_1, input bit transpose);
      return transpose ? (c * tiles_1 + r) : (r * tiles_0 + c);
   endfunction

endpackage

// File: rtl/fixed_weight_tile_streamer_if.sv
// Load channel and weight stream of one projection weight port.
// The master modport is the streamer; the slave modport is the loader/consumer side.
interface fixed_weight_tile_streamer_if #(
   parameter int PREC = 8,
   parameter int P    = 4
);
   logic [P-1:0][PREC-1:0] load_data;
   logic                   load_valid;
   logic                   load_ready;
   logic                   flush;
   logic [P-1:0][PREC-1:0] weight;
   logic                   weight_valid;
   logic                   weight_ready;
   logic                   pass_done;

   modport master (
      input  load_data, load_valid, flush, weight_ready,
      output load_ready, weight, weight_valid, pass_done
   );

   modport slave (
      output load_data, load_valid, flush, weight_ready,
      input  load_ready, weight, weight_valid, pass_done
   );
endinterface

// File: rtl/fixed_weight_tile_streamer_replay_counter.sv
// Nested tile-row / tile-column / pass counters for the replay walk.
// TRANSPOSE selects which of row or column advances fastest.
module weight_tile_replay_counter
   import fixed_weight_streamer_pkg::*;
#(
   parameter int TILES_0   = 2,
   parameter int TILES_1   = 2,
   parameter int REPEAT    = 2,
   parameter bit TRANSPOSE = 1'b0,
   localparam int RW = (TILES_1 > 1) ? $clog2(TILES_1) : 1,
   localparam int CW = (TILES_0 > 1) ? $clog2(TILES_0) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          advance,
   output logic [RW-1:0] row_next,
   output logic [CW-1:0] col_next,
   output logic          tile_last,
   output logic          pass_last
);
   localparam int NUM_TILES = TILES_0 * TILES_1;
   localparam int PW        = (REPEAT > 1) ? $clog2(REPEAT) : 1;

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [PW-1:0] pass_q, pass_d;
   logic          row_last, col_last;

   assign row_last  = (row_q == RW'(TILES_1 - 1));
   assign col_last  = (col_q == CW'(TILES_0 - 1));
   assign tile_last = (tile_index(32'(row_q), 32'(col_q), TILES_0, TILES_1, TRANSPOSE)
                       == NUM_TILES - 1);
   assign pass_last = (pass_q == PW'(REPEAT - 1));

   always_comb begin
      row_d  = row_q;
      col_d  = col_q;
      pass_d = pass_q;
      if (clear) begin
         row_d  = '0;
         col_d  = '0;
         pass_d = '0;
      end else if (advance) begin
         if (TRANSPOSE) begin
            row_d = row_last ? '0 : row_q + 1'b1;
            if (row_last) col_d = col_last ? '0 : col_q + 1'b1;
         end else begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) row_d = row_last ? '0 : row_q + 1'b1;
         end
         if (tile_last) pass_d = pass_last ? '0 : pass_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_q  <= '0;
         col_q  <= '0;
         pass_q <= '0;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         pass_q <= pass_d;
      end
   end

   // The top prefetches the tile that will be shown after this cycle's edge.
   assign row_next = row_d;
   assign col_next = col_d;

endmodule

// File: rtl/fixed_weight_tile_streamer.sv
// Loads one weight matrix as tiles, then replays it REPEAT times on a registered valid/ready stream.
// Define FIXED_WEIGHT_STREAMER_TRANSPOSE_EN for column-major replay with per-tile element transpose.
module fixed_weight_tile_streamer
   import fixed_weight_streamer_pkg::*;
#(
   parameter int WEIGHT_PRECISION_0       = 8,
   parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 4,
   parameter int WEIGHT_TENSOR_SIZE_DIM_1 = 4,
   parameter int WEIGHT_PARALLELISM_DIM_0 = 2,
   parameter int WEIGHT_PARALLELISM_DIM_1 = 2,
   parameter int REPEAT                   = 2
) (
   input logic                          clk,
   input logic                          rst,
   fixed_weight_tile_streamer_if.master bus
);
   localparam int PD0       = WEIGHT_PARALLELISM_DIM_0;
   localparam int PD1       = WEIGHT_PARALLELISM_DIM_1;
   localparam int P         = PD0 * PD1;
   localparam int TILES_0   = WEIGHT_TENSOR_SIZE_DIM_0 / PD0;
   localparam int TILES_1   = WEIGHT_TENSOR_SIZE_DIM_1 / PD1;
   localparam int NUM_TILES = TILES_0 * TILES_1;
   localparam int TW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
   localparam int RW        = (TILES_1 > 1) ? $clog2(TILES_1) : 1;
   localparam int CW        = (TILES_0 > 1) ? $clog2(TILES_0) : 1;

   localparam logic [0:0] S_LOAD   = ST_LOAD;
   localparam logic [0:0] S_STREAM = ST_STREAM;

`ifdef FIXED_WEIGHT_STREAMER_TRANSPOSE_EN
   localparam bit TRANSPOSE = 1'b1;
`else
   localparam bit TRANSPOSE = 1'b0;
`endif

   if ((WEIGHT_TENSOR_SIZE_DIM_0 % PD0) != 0 || (WEIGHT_TENSOR_SIZE_DIM_1 % PD1) != 0) begin : g_bad_tiling
      $error("tensor size must be a multiple of the tile parallelism");
   end
   if (REPEAT < 1) begin : g_bad_repeat
      $error("REPEAT must be at least 1");
   end

   typedef logic [P-1:0][WEIGHT_PRECISION_0-1:0] tile_t;

   tile_t         mem_q [NUM_TILES];
   logic [0:0]    state_q, state_d;
   logic [TW-1:0] load_cnt_q, load_cnt_d;
   tile_t         weight_q, weight_d;
   logic          weight_valid_q, weight_valid_d;

   logic          load_fire, load_last, stream_fire, stream_end, cnt_clear;
   logic          tile_last, pass_last;
   logic [RW-1:0] row_next;
   logic [CW-1:0] col_next;
   logic [TW-1:0] rd_addr;
   tile_t         tile_sel, tile_out;

   assign bus.load_ready   = (state_q == S_LOAD);
   assign load_fire        = bus.load_valid && bus.load_ready && !bus.flush;
   assign load_last        = load_fire && (load_cnt_q == TW'(NUM_TILES - 1));
   assign stream_fire      = weight_valid_q && bus.weight_ready && !bus.flush;
   assign stream_end       = stream_fire && tile_last && pass_last;
   assign cnt_clear        = bus.flush || load_last;
   assign bus.pass_done    = stream_fire && tile_last;
   assign bus.weight       = weight_q;
   assign bus.weight_valid = weight_valid_q;

   weight_tile_replay_counter #(
      .TILES_0   (TILES_0),
      .TILES_1   (TILES_1),
      .REPEAT    (REPEAT),
      .TRANSPOSE (TRANSPOSE)
   ) u_replay_counter (
      .clk       (clk),
      .rst       (rst),
      .clear     (cnt_clear),
      .advance   (stream_fire),
      .row_next  (row_next),
      .col_next  (col_next),
      .tile_last (tile_last),
      .pass_last (pass_last)
   );

   // Storage is laid out in load order, which is always row-major.
   assign rd_addr = TW'(tile_index(32'(row_next), 32'(col_next), TILES_0, TILES_1, 1'b0));

   // Forward the tile being written so a single-tile matrix streams straight after loading.
   assign tile_sel = (load_fire && (load_cnt_q == rd_addr)) ? bus.load_data : mem_q[rd_addr];

   if (TRANSPOSE) begin : g_transpose
      for (genvar gi = 0; gi < PD1; gi++) begin : g_row
         for (genvar gj = 0; gj < PD0; gj++) begin : g_col
            assign tile_out[gj*PD1+gi] = tile_sel[gi*PD0+gj];
         end
      end
   end else begin : g_passthru
      assign tile_out = tile_sel;
   end

   always_ff @(posedge clk) begin
      if (load_fire) mem_q[load_cnt_q] <= bus.load_data;
   end

   always_comb begin
      state_d        = state_q;
      load_cnt_d     = load_cnt_q;
      weight_d       = weight_q;
      weight_valid_d = weight_valid_q;
      if (bus.flush) begin
         state_d        = S_LOAD;
         load_cnt_d     = '0;
         weight_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (load_fire) begin
                  if (load_last) begin
                     load_cnt_d     = '0;
                     state_d        = S_STREAM;
                     weight_d       = tile_out;
                     weight_valid_d = 1'b1;
                  end else begin
                     load_cnt_d = load_cnt_q + 1'b1;
                  end
               end
            end
            S_STREAM: begin
               if (stream_fire) begin
                  if (stream_end) begin
                     state_d        = S_LOAD;
                     weight_valid_d = 1'b0;
                  end else begin
                     weight_d = tile_out;
                  end
               end
            end
            default: state_d = S_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_LOAD;
         load_cnt_q     <= '0;
         weight_q       <= '0;
         weight_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         load_cnt_q     <= load_cnt_d;
         weight_q       <= weight_d;
         weight_valid_q <= weight_valid_d;
      end
   end

endmodule
